// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline and long-latency requests,
// their handshake responses and the register-file write port.
interface wb_arbiter_if;
  logic        p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        stall;

  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_ready;

  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  // Requester side: drives requests, sees responses and the write.
  modport master (
    output p_valid,
    output p_rd,
    output p_data,
    output m_valid,
    output m_rd,
    output m_data,
    input  stall,
    input  m_ready,
    input  rf_we,
    input  rf_rd,
    input  rf_wdata
  );

  // Arbiter side.
  modport slave (
    input  p_valid,
    input  p_rd,
    input  p_data,
    input  m_valid,
    input  m_rd,
    input  m_data,
    output stall,
    output m_ready,
    output rf_we,
    output rf_rd,
    output rf_wdata
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares one register-file write port between
// the pipeline and a long-latency unit. Option: WB_ARB_STATS_EN.
module wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]  stall_cnt
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic {
    PRI_P,
    PRI_M
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_nxt;

  logic        conflict;
  logic        same_rd;
  logic        grant_p;
  logic        grant_m;
  logic        wr_go;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;

  // Request classification for this cycle.
  always_comb begin
    conflict = bus.p_valid && bus.m_valid;
    same_rd  = (bus.m_rd == bus.p_rd) &&
               (bus.m_rd != 5'd0);
  end

  // Grant decision; a same-register conflict always lets the
  // older M result land first.
  always_comb begin
    grant_p = 1'b0;
    grant_m = 1'b0;
    if (!reset) begin
      if (conflict) begin
        grant_m = same_rd || (state == PRI_M);
        grant_p = !grant_m;
      end else begin
        grant_m = bus.m_valid;
        grant_p = bus.p_valid;
      end
    end
  end

  // Handshake responses.
  always_comb begin
    bus.stall   = !reset && bus.p_valid && !grant_p;
    bus.m_ready = grant_m;
  end

  // Selected write; x0 is accepted but never written.
  always_comb begin
    wr_go   = 1'b0;
    wr_rd   = bus.p_rd;
    wr_data = bus.p_data;
    if (grant_m) begin
      wr_go   = (bus.m_rd != 5'd0);
      wr_rd   = bus.m_rd;
      wr_data = bus.m_data;
    end else if (grant_p) begin
      wr_go   = (bus.p_rd != 5'd0);
    end
  end

  // Starvation counter: counts lost conflicts, saturating.
  always_comb begin
    wait_nxt = wait_cnt;
    if (grant_m || !bus.m_valid) begin
      wait_nxt = 4'd0;
    end else if (conflict && state == PRI_P &&
                 wait_cnt != WAIT_MAX) begin
      wait_nxt = wait_cnt + 4'd1;
    end
  end

  // Priority FSM and starvation counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PRI_P;
      wait_cnt <= 4'd0;
    end else begin
      wait_cnt <= wait_nxt;
      unique case (1'b1)
        grant_m: state <= PRI_P;
        (state == PRI_P) && (wait_nxt == WAIT_MAX):
          state <= PRI_M;
        default: state <= state;
      endcase
    end
  end

  // Registered write port; address and data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rf_we    <= 1'b0;
      bus.rf_rd    <= 5'd0;
      bus.rf_wdata <= 32'd0;
    end else begin
      bus.rf_we <= wr_go;
      if (wr_go) begin
        bus.rf_rd    <= wr_rd;
        bus.rf_wdata <= wr_data;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  // Count cycles in which the pipeline is held off.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (bus.stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes expected
// handshakes and writes, a negedge monitor pops and compares.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_sc = 0;

  wb_arbiter_if bus ();

`ifdef WB_ARB_STATS_EN
  logic [31:0] stall_cnt;
`endif

  wb_arbiter #(
    .MAX_WAIT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef WB_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s;
    logic m;
  } hs_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  hs_t hs_q[$];
  wr_t wr_q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Monitor: handshake of this cycle, write of last grant.
  always @(negedge clk) begin
    hs_t h;
    wr_t w;
    if (hs_q.size() > 0) begin
      h = hs_q.pop_front();
      chk("stall", 32'(bus.stall), 32'(h.s));
      chk("m_ready", 32'(bus.m_ready), 32'(h.m));
    end
    if (bus.rf_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_we", 32'(bus.rf_rd), 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        chk("rf_rd", 32'(bus.rf_rd), 32'(w.rd));
        chk("rf_wdata", bus.rf_wdata, w.data);
      end
    end
  end

  task automatic cyc(
    input logic        pv,
    input logic [4:0]  prd,
    input logic [31:0] pd,
    input logic        mv,
    input logic [4:0]  mrd,
    input logic [31:0] md,
    input logic        rs,
    input logic        es,
    input logic        em,
    input logic        ew,
    input logic [4:0]  erd,
    input logic [31:0] ed
  );
    hs_t h;
    wr_t w;
    @(posedge clk);
    #1;
    reset       = rs;
    bus.p_valid = pv;
    bus.p_rd    = prd;
    bus.p_data  = pd;
    bus.m_valid = mv;
    bus.m_rd    = mrd;
    bus.m_data  = md;
    h.s = es;
    h.m = em;
    hs_q.push_back(h);
    if (ew) begin
      w.rd   = erd;
      w.data = ed;
      wr_q.push_back(w);
    end
    if (rs) exp_sc = 0;
    else if (es) exp_sc++;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.p_valid = 1'b0;
    bus.m_valid = 1'b0;
  endtask

  initial begin
    bus.p_valid = 1'b1;
    bus.p_rd    = 5'd3;
    bus.p_data  = 32'h1;
    bus.m_valid = 1'b1;
    bus.m_rd    = 5'd4;
    bus.m_data  = 32'h2;

    // reset with a conflict present: no handshake
    cyc(1, 3, 'h1, 1, 4, 'h2, 1, 0, 0, 0, 0, 0);
    cyc(1, 3, 'h1, 1, 4, 'h2, 1, 0, 0, 0, 0, 0);

    // lone P write right after reset
    cyc(1, 5, 'h1234, 0, 0, 0, 0, 0, 0, 1, 5, 'h1234);
    @(negedge clk);
    chk("rst_we", 32'(bus.rf_we), 0);
    chk("rst_rd", 32'(bus.rf_rd), 0);
    chk("rst_wdata", bus.rf_wdata, 0);
`ifdef WB_ARB_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif

    // idle: we drops, address/data hold
    idle();
    idle();
    @(negedge clk);
    chk("idle_we", 32'(bus.rf_we), 0);
    chk("hold_rd", 32'(bus.rf_rd), 5);
    chk("hold_wdata", bus.rf_wdata, 'h1234);

    // starvation: P wins 4 times, then M
    for (int i = 0; i < 4; i++)
      cyc(1, 3, 'h30, 1, 7, 'h70, 0, 0, 0, 1, 3, 'h30);
    cyc(1, 3, 'h30, 1, 7, 'h70, 0, 1, 1, 1, 7, 'h70);
    // back in PRI_P: P wins again
    cyc(1, 3, 'h31, 1, 8, 'h80, 0, 0, 0, 1, 3, 'h31);
    cyc(1, 3, 'h32, 0, 0, 0, 0, 0, 0, 1, 3, 'h32);

    // same rd: older M first, then P
    cyc(1, 9, 'hB, 1, 9, 'hA, 0, 1, 1, 1, 9, 'hA);
    cyc(1, 9, 'hB, 0, 0, 0, 0, 0, 0, 1, 9, 'hB);

    // x0 targets: accepted, never written
    cyc(0, 0, 0, 1, 0, 'hDEAD, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 12, 'hC, 0, 0, 1, 1, 12, 'hC);
    cyc(1, 0, 'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // m_valid gap clears the counter
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 'h11, 1, 2, 'h22, 0, 0, 0, 1, 1, 'h11);
    cyc(1, 1, 'h12, 0, 0, 0, 0, 0, 0, 1, 1, 'h12);
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 'h13, 1, 2, 'h22, 0, 0, 0, 1, 1, 'h13);
    cyc(1, 1, 'h13, 1, 2, 'h22, 0, 1, 1, 1, 2, 'h22);

    // reach PRI_M, then reset on the stalled conflict
    cyc(1, 4, 'h44, 1, 6, 'h66, 0, 0, 0, 1, 4, 'h44);
`ifdef WB_ARB_STATS_EN
    @(negedge clk);
    chk("stall_cnt", stall_cnt, 32'(exp_sc));
`endif
    for (int i = 0; i < 3; i++)
      cyc(1, 4, 'h44, 1, 6, 'h66, 0, 0, 0, 1, 4, 'h44);
    cyc(1, 4, 'h44, 1, 6, 'h66, 1, 0, 0, 0, 0, 0);
    // PRI_P with counter 0 after reset
    cyc(1, 4, 'h45, 1, 6, 'h66, 0, 0, 0, 1, 4, 'h45);
    @(negedge clk);
    chk("post_rst_we", 32'(bus.rf_we), 0);
`ifdef WB_ARB_STATS_EN
    chk("post_rst_stall_cnt", stall_cnt, 0);
`endif
    for (int i = 0; i < 3; i++)
      cyc(1, 4, 'h45, 1, 6, 'h66, 0, 0, 0, 1, 4, 'h45);
    cyc(1, 4, 'h45, 1, 6, 'h66, 0, 1, 1, 1, 6, 'h66);

    idle();
    idle();
    idle();
    @(negedge clk);
    chk("wr_q_empty", 32'(wr_q.size()), 0);
    chk("hs_q_empty", 32'(hs_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
